crc_frame_appender: RTL and testbench
=====================================

Name: crc_frame_appender

Overview:
- Streaming controller that sequences a `crc_calc` engine over framed byte streams.
- Passes each input frame through unchanged and computes its CRC on the fly. After the frame's last beat it appends the CRC as CRC_SIZE/DATA_WIDTH extra beats, then re-arms the engine for the next frame.
- Sits at the TX edge of a link, between the packet source and the serializer.

Parameters:
- POLY, 16'h8005: generator polynomial, forwarded to the engine.
- CRC_SIZE, 16: CRC width; must be a multiple of DATA_WIDTH.
- DATA_WIDTH, 8: stream beat width.
- INIT, 16'h0000: engine init value.
- REF_IN, 1: input reflection, forwarded.
- REF_OUT, 1: output reflection, forwarded.
- XOR_OUT, 16'h0000: final XOR, forwarded.
- CRC_LSB_FIRST, 1: 1 = append least-significant CRC beat first; 0 = most-significant first.
- CNT_WIDTH, 16: width of the frame counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o.
- in_data_i  in  DATA_WIDTH  input payload.
- in_last_i  in  1  final payload beat of the frame.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  DATA_WIDTH  payload or CRC beat.
- out_last_o  out  1  final CRC beat of the frame.
- busy_o  out  1  high from first accepted beat until the final CRC beat handshakes.
- frame_cnt_o  out  CNT_WIDTH  number of completed frames, wraps at 2^CNT_WIDTH.

Behaviour:
- FSM states: IDLE, DATA, LATCH, APPEND. Reset state is IDLE.
- Reset values: out_valid_o=0, out_last_o=0, busy_o=0, frame_cnt_o=0, CRC shift register=0, beat counter=0.
- Engine reset: the engine's synchronous rst_i is driven by the inverted, synchronised rst_n_i.
- IDLE/DATA pass-through (combinational):
  - out_valid_o=in_valid_i, out_data_o=in_data_i, out_last_o=0, in_ready_o=out_ready_i.
  - Engine valid_i = in_valid_i & out_ready_i; engine data_i = in_data_i.
- IDLE -> DATA on a handshake with in_last_i=0.
- IDLE or DATA -> LATCH on a handshake with in_last_i=1. A single-beat frame goes IDLE -> LATCH directly.
- LATCH, exactly one cycle:
  - in_ready_o=0, out_valid_o=0 (one bubble).
  - crc_o is loaded into the CRC shift register.
  - Engine soft_reset_i=1 in the same cycle; the engine holds INIT afterwards.
  - Beat counter loaded with CRC_SIZE/DATA_WIDTH-1. Next state: APPEND.
- APPEND:
  - in_ready_o=0, out_valid_o=1.
  - out_data_o = low beat of the shift register if CRC_LSB_FIRST, else the high beat.
  - On handshake: shift by DATA_WIDTH and decrement the counter.
  - out_last_o=1 when counter==0. On that handshake: frame_cnt_o increments, state -> IDLE.
- Backpressure: out_ready_i=0 in APPEND holds data, last and counter stable; out_valid_o stays high.
- busy_o = (state!=IDLE) | (in_valid_i & in_ready_o).
- Engine valid_i is never asserted in LATCH or APPEND.
- Async reset mid-frame: FSM returns to IDLE immediately. Partial output frame is abandoned (no out_last_o). Engine is re-initialised.
- No zero-length frames exist; in_last_i is only meaningful with in_valid_i.

Decomposition:
- Package crc_frame_pkg holds:
  - state enum (IDLE, DATA, LATCH, APPEND);
  - localparam CRC_BEATS = CRC_SIZE/DATA_WIDTH;
  - elaboration check that CRC_SIZE % DATA_WIDTH == 0.
- One sub-module, the existing crc_calc engine, instantiated once. No other sub-modules.

Test Plan:
- CRC-16/ARC defaults, frame "123456789" (0x31..0x39, last on 0x39), out_ready_i=1 -> 9 payload beats, 1 bubble, then 0x3D, 0xBB with out_last_o on 0xBB; frame_cnt_o=1.
- Same frame with CRC_LSB_FIRST=0 -> appended beats 0xBB, 0x3D.
- MODBUS config (INIT=16'hFFFF), same frame sent twice back-to-back -> CRC beats 0x37, 0x4B for both frames, proving soft reset re-arms to INIT; frame_cnt_o=2.
- Single-beat frame 0x00 with ARC -> IDLE->LATCH directly; appended beats 0x00, 0x00; busy_o high for 4 cycles.
- "123456789" with out_ready_i toggled 1/0 every cycle plus 3-cycle stalls during APPEND -> identical beat sequence; out_data_o stable while stalled; no input accepted during APPEND.
- rst_n_i pulsed low mid-frame (after 4 beats), then full "123456789" sent -> outputs zero during reset; next frame CRC 0xBB3D; frame_cnt_o=1.

Source files
------------

// File: rtl/crc_frame_appender_pkg.sv
// Shared types and helpers for the CRC frame appender.
// Holds the controller state encoding and the CRC beat-count helper.
package crc_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        LATCH  = 2'd2,
        APPEND = 2'd3
    } state_e;

    function automatic int crc_beats(input int crc_size, input int data_width);
        return crc_size / data_width;
    endfunction

endpackage

// File: rtl/crc_frame_appender_crc_calc.sv
// Byte-parallel CRC engine: one DATA_WIDTH beat per valid cycle.
// Synchronous reset and soft reset both return the register to INIT.
module crc_calc #(
    parameter int                  CRC_SIZE   = 16,
    parameter int                  DATA_WIDTH = 8,
    parameter logic [CRC_SIZE-1:0] POLY       = 16'h8005,
    parameter logic [CRC_SIZE-1:0] INIT       = '0,
    parameter bit                  REF_IN     = 1'b1,
    parameter bit                  REF_OUT    = 1'b1,
    parameter logic [CRC_SIZE-1:0] XOR_OUT    = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_SIZE-1:0]   crc_o
);

    logic [CRC_SIZE-1:0]   crc_q;
    logic [DATA_WIDTH-1:0] data_ref;
    logic [CRC_SIZE-1:0]   crc_ref;

    function automatic logic [CRC_SIZE-1:0] crc_step(input logic [CRC_SIZE-1:0]   c,
                                                     input logic [DATA_WIDTH-1:0] d);
        logic [CRC_SIZE-1:0] r;
        logic                fb;
        r = c;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = r[CRC_SIZE-1] ^ d[i];
            r  = {r[CRC_SIZE-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    // Reflected input is fed MSB-first into a non-reflected register.
    always_comb begin
        data_ref = data_i;
        for (int i = 0; i < DATA_WIDTH; i++)
            data_ref[i] = REF_IN ? data_i[DATA_WIDTH-1-i] : data_i[i];
    end

    always_comb begin
        crc_ref = crc_q;
        for (int i = 0; i < CRC_SIZE; i++)
            crc_ref[i] = REF_OUT ? crc_q[CRC_SIZE-1-i] : crc_q[i];
    end

    assign crc_o = crc_ref ^ XOR_OUT;

    always_ff @(posedge clk_i) begin
        if (rst_i || soft_reset_i)
            crc_q <= INIT;
        else if (valid_i)
            crc_q <= crc_step(crc_q, data_ref);
    end

endmodule

// File: rtl/crc_frame_appender.sv
// Passes framed beats through while a crc_calc engine runs, then appends the
// frame CRC as CRC_SIZE/DATA_WIDTH trailing beats and re-arms the engine.
module crc_frame_appender
    import crc_frame_pkg::*;
#(
    parameter int                  CRC_SIZE      = 16,
    parameter int                  DATA_WIDTH    = 8,
    parameter logic [CRC_SIZE-1:0] POLY          = 16'h8005,
    parameter logic [CRC_SIZE-1:0] INIT          = 16'h0000,
    parameter bit                  REF_IN        = 1'b1,
    parameter bit                  REF_OUT       = 1'b1,
    parameter logic [CRC_SIZE-1:0] XOR_OUT       = 16'h0000,
    parameter bit                  CRC_LSB_FIRST = 1'b1,
    parameter int                  CNT_WIDTH     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_last_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  frame_cnt_o
);

    localparam int CRC_BEATS = crc_beats(CRC_SIZE, DATA_WIDTH);
    localparam int BW        = (CRC_BEATS > 1) ? $clog2(CRC_BEATS) : 1;

    if (CRC_SIZE % DATA_WIDTH != 0) begin : g_bad_size
        $error("CRC_SIZE must be a multiple of DATA_WIDTH");
    end

    state_e                state_q, state_d;
    logic [1:0]            rst_sync_q;
    logic                  eng_rst;
    logic                  eng_valid;
    logic                  eng_soft;
    logic [CRC_SIZE-1:0]   crc_w;
    logic [CRC_SIZE-1:0]   sr_q;
    logic [BW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] crc_beat;
    logic                  in_hs;
    logic                  out_hs;

    assign in_hs    = in_valid_i & in_ready_o;
    assign out_hs   = out_valid_o & out_ready_i;
    assign crc_beat = CRC_LSB_FIRST ? sr_q[DATA_WIDTH-1:0] : sr_q[CRC_SIZE-1 -: DATA_WIDTH];
    assign busy_o   = (state_q != IDLE) | in_hs;

    // Engine reset asserts with rst_n_i and releases two clocks after it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            rst_sync_q <= '0;
        else
            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign eng_rst = ~rst_sync_q[1];

    crc_calc #(
        .CRC_SIZE  (CRC_SIZE),
        .DATA_WIDTH(DATA_WIDTH),
        .POLY      (POLY),
        .INIT      (INIT),
        .REF_IN    (REF_IN),
        .REF_OUT   (REF_OUT),
        .XOR_OUT   (XOR_OUT)
    ) u_crc (
        .clk_i       (clk_i),
        .rst_i       (eng_rst),
        .soft_reset_i(eng_soft),
        .valid_i     (eng_valid),
        .data_i      (in_data_i),
        .crc_o       (crc_w)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DATA: if (in_hs) state_d = in_last_i ? LATCH : DATA;
            LATCH:      state_d = APPEND;
            APPEND:     if (out_hs && cnt_q == '0) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        eng_valid   = 1'b0;
        eng_soft    = 1'b0;
        unique case (state_q)
            IDLE, DATA: begin
                out_valid_o = in_valid_i;
                out_data_o  = in_data_i;
                in_ready_o  = out_ready_i;
                eng_valid   = in_valid_i & out_ready_i;
            end
            LATCH:  eng_soft = 1'b1;
            APPEND: begin
                out_valid_o = 1'b1;
                out_data_o  = crc_beat;
                out_last_o  = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            frame_cnt_o <= '0;
        end else if (state_q == LATCH) begin
            sr_q  <= crc_w;
            cnt_q <= BW'(CRC_BEATS - 1);
        end else if (state_q == APPEND && out_hs) begin
            sr_q  <= CRC_LSB_FIRST ? (sr_q >> DATA_WIDTH) : (sr_q << DATA_WIDTH);
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0)
                frame_cnt_o <= frame_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_crc_frame_appender.sv
// Three appender configs (ARC LSB-first, ARC MSB-first, MODBUS) share one
// stimulus stream; each output is scored against a reflected-table CRC model.
module tb_crc_frame_appender;

    localparam int ND = 3;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       is_crc;
        int         idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic [ND-1:0] in_ready, out_valid, out_last, busy;
    logic [7:0]    out_data  [ND];
    logic [15:0]   frame_cnt [ND];

    always #5 clk = ~clk;

    for (genvar k = 0; k < ND; k++) begin : g_dut
        crc_frame_appender #(
            .INIT         (k == 2 ? 16'hFFFF : 16'h0000),
            .CRC_LSB_FIRST(k == 1 ? 1'b0 : 1'b1)
        ) dut (
            .clk_i      (clk),
            .rst_n_i    (rst_n),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready[k]),
            .in_data_i  (in_data),
            .in_last_i  (in_last),
            .out_valid_o(out_valid[k]),
            .out_ready_i(out_ready),
            .out_data_o (out_data[k]),
            .out_last_o (out_last[k]),
            .busy_o     (busy[k]),
            .frame_cnt_o(frame_cnt[k])
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reflected CRC-16 (poly 0x8005 reversed = 0xA001), byte-at-a-time.
    function automatic logic [15:0] ref_crc(input bq_t b, input logic [15:0] init);
        logic [15:0] c;
        c = init;
        foreach (b[i]) begin
            c ^= {8'h00, b[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    exp_t        exp_q [ND][$];
    bq_t         cur;
    logic [ND-1:0] active;
    logic [15:0] mcnt [ND];
    logic [ND-1:0] prev_stall;
    logic [7:0]  prev_data [ND];
    logic [ND-1:0] prev_last;
    logic [7:0]  crc_seen [ND][2];
    int          busy_cycles = 0;
    int          rmode = 0;
    int          pc = 0;

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic        hs;
        logic [15:0] c;
        exp_t        e;
        if (!rst_n) begin
            for (int k = 0; k < ND; k++) begin
                chk($sformatf("rst_valid%0d", k), out_valid[k], 0);
                chk($sformatf("rst_last%0d", k), out_last[k], 0);
                chk($sformatf("rst_busy%0d", k), busy[k], 0);
                chk($sformatf("rst_cnt%0d", k), frame_cnt[k], 0);
                exp_q[k].delete();
                mcnt[k] = '0;
            end
            active = '0;
            prev_stall = '0;
            cur.delete();
        end else begin
            hs = in_valid && in_ready[0];
            if (busy[0]) busy_cycles++;
            for (int k = 0; k < ND; k++) begin
                chk($sformatf("frame_cnt%0d", k), frame_cnt[k], mcnt[k]);
                chk($sformatf("busy%0d", k), busy[k], active[k] || (in_valid && in_ready[k]));
                if (exp_q[k].size() > 0)
                    chk($sformatf("in_blocked%0d", k), in_ready[k], 0);
                if (prev_stall[k]) begin
                    chk($sformatf("stall_valid%0d", k), out_valid[k], 1);
                    chk($sformatf("stall_data%0d", k), out_data[k], prev_data[k]);
                    chk($sformatf("stall_last%0d", k), out_last[k], prev_last[k]);
                end
            end
            if (hs) begin
                cur.push_back(in_data);
                for (int k = 0; k < ND; k++) begin
                    exp_q[k].push_back('{d: in_data, last: 1'b0, is_crc: 1'b0, idx: 0});
                    active[k] = 1'b1;
                end
                if (in_last) begin
                    for (int k = 0; k < ND; k++) begin
                        c = ref_crc(cur, (k == 2) ? 16'hFFFF : 16'h0000);
                        exp_q[k].push_back('{d: (k == 1) ? c[15:8] : c[7:0], last: 1'b0, is_crc: 1'b1, idx: 0});
                        exp_q[k].push_back('{d: (k == 1) ? c[7:0] : c[15:8], last: 1'b1, is_crc: 1'b1, idx: 1});
                    end
                    cur.delete();
                end
            end
            for (int k = 0; k < ND; k++) begin
                if (out_valid[k] && out_ready) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("spurious_beat%0d", k), out_data[k], 0);
                        chk($sformatf("spurious_valid%0d", k), 1, 0);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("data%0d", k), out_data[k], e.d);
                        chk($sformatf("last%0d", k), out_last[k], e.last);
                        if (e.is_crc) crc_seen[k][e.idx] = out_data[k];
                        if (e.last) begin
                            mcnt[k] = mcnt[k] + 16'd1;
                            active[k] = 1'b0;
                        end
                    end
                end
                prev_stall[k] = out_valid[k] && !out_ready;
                prev_data[k]  = out_data[k];
                prev_last[k]  = out_last[k];
            end
        end
    end

    // Downstream ready: 0 = always, 1 = toggle with 3-cycle stalls on CRC beats, 2 = random.
    always @(posedge clk) begin
        #1;
        pc++;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (exp_q[0].size() > 0) ? (pc % 4 == 3) : pc[0];
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send_beat(input logic [7:0] d, input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready[0] && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_frame(input bq_t f, input int gap_max);
        foreach (f[i]) begin
            send_beat(f[i], i == f.size() - 1);
            if (gap_max > 0)
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (t < 400 && (exp_q[0].size() > 0 || exp_q[1].size() > 0 || exp_q[2].size() > 0)) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 400) chk("idle_timeout", 1, 0);
    endtask

    task automatic chk_crc(input string tag, input int k, input logic [7:0] b0, input logic [7:0] b1);
        chk({tag, "_b0"}, crc_seen[k][0], b0);
        chk({tag, "_b1"}, crc_seen[k][1], b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t chk9, one, fr;
        int  frames;
        chk9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        one  = '{8'h00};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        rmode = 0;
        busy_cycles = 0;
        send_frame(chk9, 0);
        wait_idle();
        chk("check_busy_cycles", busy_cycles, 12);
        chk_crc("arc_lsb", 0, 8'h3D, 8'hBB);
        chk_crc("arc_msb", 1, 8'hBB, 8'h3D);
        chk_crc("modbus1", 2, 8'h37, 8'h4B);
        chk("cnt_after1", frame_cnt[0], 1);

        crc_seen[2][0] = 8'h00;
        crc_seen[2][1] = 8'h00;
        send_frame(chk9, 0);
        send_frame(chk9, 0);
        wait_idle();
        chk_crc("modbus_b2b", 2, 8'h37, 8'h4B);
        chk("cnt_modbus", frame_cnt[2], 3);

        busy_cycles = 0;
        send_frame(one, 0);
        wait_idle();
        chk("single_busy_cycles", busy_cycles, 4);
        chk_crc("single", 0, 8'h00, 8'h00);

        rmode = 1;
        crc_seen[0][0] = 8'h00;
        crc_seen[0][1] = 8'h00;
        send_frame(chk9, 0);
        wait_idle();
        chk_crc("stalled_arc", 0, 8'h3D, 8'hBB);
        chk_crc("stalled_msb", 1, 8'hBB, 8'h3D);

        rmode = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_beat(chk9[i], 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("cnt_after_rst", frame_cnt[0], 0);
        crc_seen[0][0] = 8'h00;
        crc_seen[0][1] = 8'h00;
        send_frame(chk9, 0);
        wait_idle();
        chk_crc("post_rst", 0, 8'h3D, 8'hBB);
        chk("cnt_post_rst", frame_cnt[0], 1);

        frames = 1;
        for (int f = 0; f < 40; f++) begin
            rmode = $urandom_range(0, 2);
            fr.delete();
            repeat ($urandom_range(1, 12)) fr.push_back(8'($urandom));
            send_frame(fr, $urandom_range(0, 2));
            frames++;
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        for (int k = 0; k < ND; k++)
            chk($sformatf("final_cnt%0d", k), frame_cnt[k], frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
